// File: rtl/dsram_pkg.sv
// Shared types and constants for the data-SRAM responder slice.
package dsram_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef struct packed {
    logic        is_load;
    logic [31:0] data;
    logic [7:0]  age;
  } q_entry_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [31:0] lane_merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/dsram_responder_if.sv
// Request/response bundle between the EXE/MEM stages and the data SRAM.
interface dsram_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/dsram_resp_queue.sv
// In-order response queue: entries age each cycle, head answers at age LATENCY-1.
import dsram_pkg::*;

module dsram_resp_queue #(
  parameter int LATENCY   = 2,
  parameter int MAX_OUTST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        push_load,
  input  logic [31:0] push_data,
  output logic        full,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int PW = $clog2(MAX_OUTST);

  q_entry_t      q [MAX_OUTST];
  logic [PW:0]   wp;
  logic [PW:0]   rp;
  logic          empty;
  logic          pop;
  q_entry_t      head;

  assign empty = (wp == rp);
  assign full  = (wp[PW] != rp[PW]) &&
                 (wp[PW-1:0] == rp[PW-1:0]);
  assign head  = q[rp[PW-1:0]];
  assign pop   = !empty &&
                 (head.age == 8'(LATENCY - 1));

  assign data_ok = pop && !reset;
  assign rdata   = (data_ok && head.is_load) ?
                   head.data : 32'd0;

  // Only live entries matter; stale slots may age freely.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      for (int i = 0; i < MAX_OUTST; i++)
        q[i].age <= q[i].age + 8'd1;
      if (push) begin
        q[wp[PW-1:0]] <= '{is_load: push_load,
                           data:    push_data,
                           age:     8'd0};
        wp <= wp + 1'b1;
      end
      if (pop)
        rp <= rp + 1'b1;
    end
  end

endmodule

// File: rtl/dsram_responder.sv
// Behavioural data SRAM responder; define DSRAM_RAND_STALL_EN
// to add pseudo-random addr_ok stalls from a 16-bit LFSR.
import dsram_pkg::*;

module dsram_responder #(
  parameter int WORDS_LOG2 = 12,
  parameter int LATENCY    = 2,
  parameter int MAX_OUTST  = 4
) (
  input  logic             clk,
  input  logic             reset,
  dsram_responder_if.slave bus
);

  logic [31:0]           mem [2**WORDS_LOG2];
  logic [WORDS_LOG2-1:0] idx;
  logic                  full;
  logic                  stall;
  logic                  accept;
  logic [31:0]           rd_word;
  logic                  unused_ok;

  assign idx     = bus.addr[WORDS_LOG2+1:2];
  assign rd_word = mem[idx];

  assign unused_ok = ^{bus.size, bus.addr[1:0],
                       bus.addr[31:WORDS_LOG2+2]};

`ifdef DSRAM_RAND_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset)
      lfsr <= LFSR_SEED;
    else
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign bus.addr_ok = !reset && !full && !stall;
  assign accept      = bus.req && bus.addr_ok;

  // Loads sample rd_word before this edge's store lands.
  always_ff @(posedge clk) begin
    if (accept && bus.wr)
      mem[idx] <= lane_merge(rd_word, bus.wdata, bus.wstrb);
  end

  dsram_resp_queue #(
    .LATENCY  (LATENCY),
    .MAX_OUTST(MAX_OUTST)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (accept),
    .push_load(!bus.wr),
    .push_data(bus.wr ? 32'd0 : rd_word),
    .full     (full),
    .data_ok  (bus.data_ok),
    .rdata    (bus.rdata)
  );

endmodule

// File: tb/tb_dsram_responder.sv
// Scoreboard bench: d0 has LATENCY=2, d1 has LATENCY=4 (both MAX_OUTST=4).
module tb_dsram_responder;

  logic        clk  = 1'b0;
  logic        rst0 = 1'b1;
  logic        rst1 = 1'b1;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic        t_wr = 1'b0;
  logic [1:0]  t_size = 2'd2;
  logic [31:0] t_addr = '0;
  logic [31:0] t_wdata = '0;
  logic [3:0]  t_wstrb = '0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dsram_responder_if ia ();
  dsram_responder_if ib ();

  assign ia.req = req0;   assign ib.req = req1;
  assign ia.wr = t_wr;    assign ib.wr = t_wr;
  assign ia.size = t_size;  assign ib.size = t_size;
  assign ia.addr = t_addr;  assign ib.addr = t_addr;
  assign ia.wstrb = t_wstrb; assign ib.wstrb = t_wstrb;
  assign ia.wdata = t_wdata; assign ib.wdata = t_wdata;

  dsram_responder #(.WORDS_LOG2(12), .LATENCY(2), .MAX_OUTST(4))
    u0 (.clk(clk), .reset(rst0), .bus(ia.slave));
  dsram_responder #(.WORDS_LOG2(12), .LATENCY(4), .MAX_OUTST(4))
    u1 (.clk(clk), .reset(rst1), .bus(ib.slave));

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] m0[int];
  logic [31:0] m1[int];
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic int widx(logic [31:0] a);
    return int'(a[13:2]);
  endfunction

  function automatic logic [31:0] mrd(int d, logic [31:0] a);
    if (d == 0) return m0.exists(widx(a)) ? m0[widx(a)] : 'x;
    return m1.exists(widx(a)) ? m1[widx(a)] : 'x;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o,
                                        logic [31:0] n,
                                        logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic mon(int d, logic dok, logic [31:0] rd);
    exp_t e;
    bit   due;
    due = 0;
    if (d == 0) begin
      if (q0.size() > 0 && q0[0].due == cyc) begin
        due = 1; e = q0.pop_front();
      end
    end else begin
      if (q1.size() > 0 && q1[0].due == cyc) begin
        due = 1; e = q1.pop_front();
      end
    end
    if (due) begin
      chk($sformatf("d%0d_data_ok", d), 32'(dok), 32'd1);
      if (dok) chk($sformatf("d%0d_rdata", d), rd, e.data);
    end else begin
      chk($sformatf("d%0d_data_ok_idle", d), 32'(dok), 32'd0);
      chk($sformatf("d%0d_rdata_idle", d), rd, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      mon(0, ia.data_ok, ia.rdata);
      mon(1, ib.data_ok, ib.rdata);
    end
  end

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic issue(int d, logic wr, logic [31:0] a,
                       logic [3:0] s, logic [31:0] wd,
                       output int st);
    logic        ok;
    exp_t        e;
    logic [31:0] cur;
    t_wr = wr; t_addr = a; t_wstrb = s; t_wdata = wd;
    if (d == 0) req0 = 1'b1; else req1 = 1'b1;
    st = 0;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = (d == 0) ? ia.addr_ok : ib.addr_ok;
      if (!ok) st++;
    end
    if (!ok) begin
      chk("accept_timeout", 32'(ok), 32'd1);
    end else begin
      cur    = mrd(d, a);
      e.due  = cyc + ((d == 0) ? 2 : 4);
      e.data = wr ? 32'd0 : cur;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      if (wr) begin
        if (d == 0) m0[widx(a)] = merge(cur, wd, s);
        else        m1[widx(a)] = merge(cur, wd, s);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    req0 = 1'b0; req1 = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int st;
    int tot;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_addr_ok0", 32'(ia.addr_ok), 32'd0);
    chk("rst_addr_ok1", 32'(ib.addr_ok), 32'd0);
    @(posedge clk); #1;
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    chk("post_rst_addr_ok0", 32'(ia.addr_ok), 32'd1);
    chk("post_rst_addr_ok1", 32'(ib.addr_ok), 32'd1);
    @(posedge clk); #1;

    // Word store then load
    issue(0, 1, 32'h100, 4'hF, 32'hDEADBEEF, st);
    issue(0, 0, 32'h100, 4'h0, 32'h0, st);
    idle(4);

    // Byte-lane store over an existing word
    issue(0, 1, 32'h104, 4'hF, 32'h11223344, st);
    issue(0, 1, 32'h104, 4'h1, 32'h000000AA, st);
    issue(0, 0, 32'h104, 4'h0, 32'h0, st);
    idle(4);

    // Store->load and load->store on one address
    issue(0, 1, 32'h300, 4'hF, 32'h12345678, st);
    issue(0, 0, 32'h300, 4'h0, 32'h0, st);
    issue(0, 0, 32'h300, 4'h0, 32'h0, st);
    issue(0, 1, 32'h300, 4'hC, 32'h9ABCDEF0, st);
    issue(0, 0, 32'h300, 4'h0, 32'h0, st);
    // Aliasing above the index bits
    issue(0, 0, 32'h0000_4100, 4'h0, 32'h0, st);
    issue(0, 0, 32'hFFFF_C104, 4'h0, 32'h0, st);
    idle(4);

    // Back-to-back loads at LATENCY=2: never stalls
    for (int i = 0; i < 8; i++)
      issue(0, 1, 32'h400 + 32'(4*i), 4'hF, 32'hA5000000 + 32'(i), st);
    idle(4);
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      issue(0, 0, 32'h400 + 32'(4*(7-i)), 4'h0, 32'h0, st);
      tot += st;
    end
    chk("b2b_stalls", 32'(tot), 32'd0);
    idle(4);

    // LATENCY=4: fifth back-to-back load stalls exactly one cycle
    for (int i = 0; i < 5; i++)
      issue(1, 1, 32'h500 + 32'(4*i), 4'hF, 32'h5A000000 + 32'(i), st);
    idle(6);
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      issue(1, 0, 32'h500 + 32'(4*i), 4'h0, 32'h0, st);
      tot += st;
    end
    chk("fill_stalls", 32'(tot), 32'd0);
    issue(1, 0, 32'h510, 4'h0, 32'h0, st);
    chk("full_stall", 32'(st), 32'd1);
    idle(8);

    // Reset with three requests outstanding
    issue(1, 1, 32'h200, 4'hF, 32'hCAFEF00D, st);
    issue(1, 0, 32'h500, 4'h0, 32'h0, st);
    issue(1, 0, 32'h504, 4'h0, 32'h0, st);
    rst1 = 1'b1; req1 = 1'b0;
    q1.delete();
    @(negedge clk);
    chk("mid_rst_addr_ok", 32'(ib.addr_ok), 32'd0);
    @(posedge clk); #1;
    rst1 = 1'b0;
    @(negedge clk);
    chk("after_rst_addr_ok", 32'(ib.addr_ok), 32'd1);
    @(posedge clk); #1;
    idle(6);
    issue(1, 0, 32'h200, 4'h0, 32'h0, st);
    idle(8);

    chk("drain0", 32'(q0.size()), 32'd0);
    chk("drain1", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
